boreal_adc_frame_capture: RTL and testbench
===========================================

# boreal_adc_frame_capture

Serial front end that reads one 8-channel, 24-bit sample frame from the external EEG ADC on each data-ready event. It assembles the frame into the flat 192-bit channel array and asserts a one-cycle valid strobe. It sits directly upstream of the 8-channel EEG fusion filter and drives that block's raw array and data-valid inputs. It also handles read-clock generation, chip-select sequencing, data-ready synchronisation and overrun accounting.

## Interface
Reset is asynchronous and active-low (`rst_n`); single clock `clk`.

Parameters:
- SCLK_DIV, 4: `clk` cycles per SCLK half-period; legal range 3..255.
- CS_SETUP, 2: `clk` cycles from `adc_cs_n` falling to first SCLK rising edge; legal range 1..15.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, capture enable; low aborts/inhibits capture.
- adc_drdy_n, in, 1, ADC data-ready, asynchronous, active-low.
- adc_miso, in, 1, ADC serial data, asynchronous.
- adc_sclk, out, 1, serial clock to ADC; idles low.
- adc_cs_n, out, 1, ADC chip select, active-low.
- raw_eeg_array, out, 192, channel i in bits [i*24 +: 24].
- data_valid, out, 1, one-cycle pulse; array updated in the same cycle.
- frame_err, out, 1, one-cycle pulse on rejected frame.
- overrun_cnt, out, 8, saturating count of dropped DRDY events.

## Operation
- `adc_drdy_n` and `adc_miso` each pass through a 2-flop synchroniser.
- Falling-edge detect on synced DRDY.
- Frame length is 216 bits, MSB first: 24-bit status word, then ch0..ch7, 24 bits each.
- States:
  - IDLE: `cs_n`=1, `sclk`=0. Moves to SETUP on a DRDY fall while `enable`=1.
  - SETUP: `cs_n`=0 for CS_SETUP cycles, then SHIFT.
  - SHIFT: runs 216 SCLK periods. Each period is SCLK_DIV cycles high, then SCLK_DIV cycles low. The synced MISO bit shifts into a 216-bit register on the last cycle of each high phase. After bit 215 (end of its low phase), moves to PUBLISH.
  - PUBLISH: one cycle. `cs_n`=1. Writes the channel bits into `raw_eeg_array`, pulses `data_valid`, then returns to IDLE.
- `raw_eeg_array` changes only in PUBLISH; it holds its last value otherwise.
- A DRDY fall detected in any state other than IDLE is ignored and increments `overrun_cnt`; the count saturates at 255.
- `enable` falling in SETUP or SHIFT aborts: next cycle IDLE, `cs_n`=1, `sclk`=0, no publish, no error.
- A DRDY fall in the same cycle as PUBLISH counts as an overrun.
- Reset mid-frame: all outputs and state return to reset values immediately; the partial frame is discarded.

## Timing
- Reset values:
  - `adc_sclk`=0, `adc_cs_n`=1.
  - `raw_eeg_array`=0.
  - `data_valid`=0, `frame_err`=0, `overrun_cnt`=0.
  - State IDLE.
- `adc_drdy_n` first sampled low at cycle R gives edge detect at D=R+2.
- Latency:
  - SETUP spans D+1 .. D+CS_SETUP.
  - SHIFT spans 432·SCLK_DIV cycles.
  - PUBLISH and `data_valid` fall at D+1+CS_SETUP+432·SCLK_DIV. With defaults this is R+1733.
- The sampling point is at least SCLK_DIV−2 cycles after the SCLK rising edge. This is why SCLK_DIV≥3: it covers synchroniser delay for data launched on the rising edge.
- Minimum DRDY spacing without overrun is the full frame time plus 3 cycles.

## Configuration
- BOREAL_ADC_STATUS_CHECK_EN defined:
  - PUBLISH checks status[23:20]==4'b1100.
  - On mismatch it pulses `frame_err` instead of `data_valid` and leaves `raw_eeg_array` unchanged.
- Undefined: status word is shifted and discarded, `frame_err` is tied 0, and every completed frame publishes.

## Structure
- Package `boreal_adc_pkg` holds:
  - constants NUM_CH=8, CH_BITS=24, STATUS_BITS=24, FRAME_BITS=216, STATUS_SYNC=4'b1100;
  - the state enum {IDLE, SETUP, SHIFT, PUBLISH}.
- One sub-module, `boreal_sync2`: parameterised 2-flop synchroniser with reset value input. Instanced for DRDY (reset 1) and MISO (reset 0).

## Test plan
- Reset, then one DRDY fall with a model returning status 0xC00000 and ch i = 0x100000+i → exactly one `data_valid` at R+1733 (defaults). `raw_eeg_array[i*24+:24]`=0x100000+i. `adc_cs_n` is low for exactly CS_SETUP+1728 cycles.
- Channel pattern ch0=0x800001, ch7=0x7FFFFF → bit-exact placement; MSB-first ordering confirmed. Exactly 216 SCLK rising edges per frame.
- Second DRDY fall mid-SHIFT → `overrun_cnt`=1, single `data_valid`. Then 300 overrun events → `overrun_cnt`=255 and held.
- `enable` dropped after bit 100 → `cs_n`=1 and `sclk`=0 next cycle, no `data_valid`, array unchanged. Next DRDY captures normally.
- With BOREAL_ADC_STATUS_CHECK_EN, status 0x400000 → `frame_err` pulse, no `data_valid`, array unchanged. Without the macro, the same stimulus publishes.
- `rst_n` asserted mid-SHIFT → all outputs at reset values the same cycle. After release, a new DRDY produces a correct frame.

Source files
------------

// File: rtl/boreal_adc_pkg.sv
// Shared constants, FSM state encoding and channel unpack helper for the EEG ADC frame capture.
// Pure declarations; no latency or backpressure of its own.
package boreal_adc_pkg;

    localparam int NUM_CH      = 8;
    localparam int CH_BITS     = 24;
    localparam int STATUS_BITS = 24;
    localparam int FRAME_BITS  = STATUS_BITS + NUM_CH * CH_BITS;
    localparam logic [3:0] STATUS_SYNC = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        PUBLISH
    } state_t;

    // Serial order is ch0 first, so ch0 sits in the most significant slice of the shift register.
    function automatic logic [NUM_CH*CH_BITS-1:0] unpack_channels(
        input logic [NUM_CH*CH_BITS-1:0] bits
    );
        logic [NUM_CH*CH_BITS-1:0] arr;
        arr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arr[i*CH_BITS +: CH_BITS] = bits[(NUM_CH-1-i)*CH_BITS +: CH_BITS];
        end
        return arr;
    endfunction

endpackage

// File: rtl/boreal_adc_frame_capture_sync.sv
// Two-flop synchroniser with a run-time reset value, for asynchronous ADC inputs.
// Latency: 2 clk cycles; no backpressure (free-running sampler).
module boreal_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/boreal_adc_frame_capture.sv
// Reads one 216-bit status+8ch frame per DRDY fall and publishes it as a 192-bit array (BOREAL_ADC_STATUS_CHECK_EN adds status-word check).
// Latency: data_valid 1733 clk after DRDY low sampled (defaults); no backpressure: busy DRDY falls are dropped and counted.
module boreal_adc_frame_capture
    import boreal_adc_pkg::*;
#(
    parameter int SCLK_DIV = 4,
    parameter int CS_SETUP = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      adc_drdy_n,
    input  logic                      adc_miso,
    output logic                      adc_sclk,
    output logic                      adc_cs_n,
    output logic [NUM_CH*CH_BITS-1:0] raw_eeg_array,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic [7:0]                overrun_cnt
);

    localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] LAST_BIT   = 8'(FRAME_BITS - 1);

    logic drdy_s;
    logic miso_s;
    logic drdy_fall;
    logic status_ok;

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [7:0]                bit_q, bit_d;
    logic                      sclk_q, sclk_d;
    logic [FRAME_BITS-1:0]     shreg_q, shreg_d;
    logic [NUM_CH*CH_BITS-1:0] raw_q, raw_d;
    logic                      dv_q, dv_d;
    logic                      err_q, err_d;
    logic [7:0]                ovr_q, ovr_d;
    logic                      drdy_prev_q, drdy_prev_d;

    boreal_sync2 #(.WIDTH(1)) u_sync_drdy (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (1'b1),
        .d       (adc_drdy_n),
        .q       (drdy_s)
    );

    boreal_sync2 #(.WIDTH(1)) u_sync_miso (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (1'b0),
        .d       (adc_miso),
        .q       (miso_s)
    );

    assign drdy_fall = drdy_prev_q & ~drdy_s;

`ifdef BOREAL_ADC_STATUS_CHECK_EN
    assign status_ok = (shreg_q[FRAME_BITS-1 -: 4] == STATUS_SYNC);
`else
    // Status word is shifted through but never inspected in this build.
    logic status_unused;
    assign status_unused = shreg_q[FRAME_BITS-1];
    assign status_ok     = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        shreg_d     = shreg_q;
        raw_d       = raw_q;
        dv_d        = 1'b0;
        err_d       = 1'b0;
        ovr_d       = ovr_q;
        drdy_prev_d = drdy_s;

        if (drdy_fall && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (drdy_fall && enable) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LAST;
                end
            end
            SETUP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = SHIFT;
                    cnt_d   = 8'd0;
                    bit_d   = 8'd0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SHIFT: begin
                if (!enable) begin
                    state_d = IDLE;
                    sclk_d  = 1'b0;
                end else if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (sclk_q) begin
                        // Sample at the end of the high phase, well clear of the ADC's launch edge.
                        shreg_d = {shreg_q[FRAME_BITS-2:0], miso_s};
                        sclk_d  = 1'b0;
                    end else if (bit_q == LAST_BIT) begin
                        state_d = PUBLISH;
                        if (status_ok) begin
                            raw_d = unpack_channels(shreg_q[NUM_CH*CH_BITS-1:0]);
                            dv_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PUBLISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            bit_q       <= 8'd0;
            sclk_q      <= 1'b0;
            shreg_q     <= '0;
            raw_q       <= '0;
            dv_q        <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 8'd0;
            drdy_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            shreg_q     <= shreg_d;
            raw_q       <= raw_d;
            dv_q        <= dv_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            drdy_prev_q <= drdy_prev_d;
        end
    end

    assign adc_cs_n      = !((state_q == SETUP) || (state_q == SHIFT));
    assign adc_sclk      = sclk_q;
    assign raw_eeg_array = raw_q;
    assign data_valid    = dv_q;
    assign frame_err     = err_q;
    assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_boreal_adc_frame_capture.sv
// Randomised bench for boreal_adc_frame_capture: ADC serial model plus a cycle-indexed frame-window reference.
`timescale 1ns/1ps
module tb_boreal_adc_frame_capture;
    import boreal_adc_pkg::*;

    localparam int SCLK_DIV = 4;
    localparam int CS_SETUP = 2;
    localparam int PUB_OFF  = CS_SETUP + 2 * FRAME_BITS * SCLK_DIV;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         adc_drdy_n = 1'b1;
    logic         adc_miso = 1'b0;
    logic         adc_sclk;
    logic         adc_cs_n;
    logic [191:0] raw_eeg_array;
    logic         data_valid;
    logic         frame_err;
    logic [7:0]   overrun_cnt;

    always #5 clk = ~clk;

    boreal_adc_frame_capture #(.SCLK_DIV(SCLK_DIV), .CS_SETUP(CS_SETUP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .adc_drdy_n    (adc_drdy_n),
        .adc_miso      (adc_miso),
        .adc_sclk      (adc_sclk),
        .adc_cs_n      (adc_cs_n),
        .raw_eeg_array (raw_eeg_array),
        .data_valid    (data_valid),
        .frame_err     (frame_err),
        .overrun_cnt   (overrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ADC model: frame content, launched MSB first on each SCLK rising edge.
    logic [23:0]  st_word = 24'h0;
    logic [23:0]  ch [8];
    logic [215:0] fb = '0;
    int           bit_idx = 0;

    function automatic logic [191:0] chan_vec();
        logic [191:0] v;
        for (int i = 0; i < 8; i++) v[i*24 +: 24] = ch[i];
        return v;
    endfunction

    task automatic set_frame(input logic [23:0] s);
        st_word = s;
        fb[215 -: 24] = s;
        for (int i = 0; i < 8; i++) fb[191 - 24*i -: 24] = ch[i];
    endtask

    task automatic rand_channels();
        for (int i = 0; i < 8; i++) ch[i] = 24'($urandom);
    endtask

    always @(negedge adc_cs_n or posedge adc_sclk) begin
        if (adc_sclk) begin
            if (bit_idx < 216) adc_miso = fb[215 - bit_idx];
            bit_idx++;
        end else begin
            bit_idx = 0;
        end
    end

    // Reference model, indexed by clk rising-edge count: a DRDY low first sampled at edge R
    // is acted on at edge R+2; the frame then owns the bus for PUB_OFF intervals and publishes in the next.
    int           cyc = 0;
    bit           h0 = 1, h1 = 1, h2 = 1, h3 = 1;
    bit           act = 0;
    int           fs = 0;
    int           end_e = 0;
    logic [191:0] pend = '0;
    bit           pend_ok = 1;
    logic [191:0] m_raw = '0;
    logic [7:0]   m_ovr = 8'd0;
    bit           exp_dv = 0;
    bit           exp_err = 0;

    int dv_cnt = 0, err_cnt = 0, cs_low_cnt = 0, rise_cnt = 0, last_dv_cyc = -1;
    bit sclk_prev = 0;

    task automatic model_step();
        bit fall, busy;
        h3 = h2; h2 = h1; h1 = h0; h0 = adc_drdy_n;
        fall = (h2 == 1'b0) && (h3 == 1'b1);
        busy = act && (cyc - 1 >= fs) && (cyc - 1 <= end_e);
        exp_dv = 0;
        exp_err = 0;
        if (fall) begin
            if (busy) begin
                if (m_ovr != 8'd255) m_ovr = m_ovr + 8'd1;
            end else if (enable) begin
                act = 1;
                fs = cyc;
                end_e = cyc + PUB_OFF;
                pend = chan_vec();
`ifdef BOREAL_ADC_STATUS_CHECK_EN
                pend_ok = (st_word[23:20] == 4'b1100);
`else
                pend_ok = 1;
`endif
            end
        end
        if (busy && !enable && end_e == fs + PUB_OFF && cyc - 1 <= fs + PUB_OFF - 1) end_e = cyc - 1;
        if (act && cyc == fs + PUB_OFF && end_e == fs + PUB_OFF) begin
            if (pend_ok) begin
                m_raw = pend;
                exp_dv = 1;
            end else begin
                exp_err = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit ni, e_cs, e_sclk;
        if (clk) cyc++;
        if (!rst_n) begin
            h0 = 1; h1 = 1; h2 = 1; h3 = 1;
            act = 0; m_raw = '0; m_ovr = 8'd0; exp_dv = 0; exp_err = 0;
        end else begin
            model_step();
        end
        #1;
        ni = act && cyc >= fs && cyc <= end_e;
        e_cs = !(ni && cyc <= fs + PUB_OFF - 1);
        e_sclk = 0;
        if (ni && cyc >= fs + CS_SETUP && cyc <= fs + PUB_OFF - 1)
            e_sclk = (((cyc - fs - CS_SETUP) / SCLK_DIV) % 2) == 0;
        chk("cs_n", 192'(adc_cs_n), 192'(e_cs));
        chk("sclk", 192'(adc_sclk), 192'(e_sclk));
        chk("data_valid", 192'(data_valid), 192'(exp_dv));
        chk("frame_err", 192'(frame_err), 192'(exp_err));
        chk("overrun_cnt", 192'(overrun_cnt), 192'(m_ovr));
        chk("raw_eeg_array", raw_eeg_array, m_raw);
        if (data_valid) begin dv_cnt++; last_dv_cyc = cyc; end
        if (frame_err) err_cnt++;
        if (!adc_cs_n) cs_low_cnt++;
        if (adc_sclk && !sclk_prev) rise_cnt++;
        sclk_prev = adc_sclk;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drdy_fall(output int m);
        @(negedge clk);
        adc_drdy_n = 1'b0;
        m = cyc;
        repeat (3) @(negedge clk);
        adc_drdy_n = 1'b1;
    endtask

    initial begin
        int m, m2, dv0, err0, cs0, r0;
        logic [191:0] exp_last;
        for (int i = 0; i < 8; i++) ch[i] = 24'h0;
        set_frame(24'h0);
        exp_last = '0;

        cycles(3);
        chk("reset cs_n", 192'(adc_cs_n), 192'(1));
        chk("reset sclk", 192'(adc_sclk), 192'(0));
        chk("reset raw", raw_eeg_array, 192'(0));
        chk("reset ovr", 192'(overrun_cnt), 192'(0));
        rst_n = 1'b1;
        enable = 1'b1;
        cycles(5);

        // Frame A: known pattern, exact latency, CS width and SCLK count.
        for (int i = 0; i < 8; i++) ch[i] = 24'h100000 + 24'(i);
        set_frame(24'hC00000);
        dv0 = dv_cnt; cs0 = cs_low_cnt; r0 = rise_cnt;
        drdy_fall(m);
        cycles(1740);
        chk("A dv count", 192'(dv_cnt - dv0), 192'(1));
        chk("A dv cycle", 192'(last_dv_cyc), 192'(m + 1733));
        chk("A ch0", 192'(raw_eeg_array[0 +: 24]), 192'(24'h100000));
        chk("A ch3", 192'(raw_eeg_array[72 +: 24]), 192'(24'h100003));
        chk("A ch7", 192'(raw_eeg_array[168 +: 24]), 192'(24'h100007));
        chk("A cs low cycles", 192'(cs_low_cnt - cs0), 192'(1730));
        chk("A sclk rises", 192'(rise_cnt - r0), 192'(216));
        exp_last = chan_vec();

        // Frame B: asymmetric end channels confirm MSB-first ordering.
        rand_channels();
        ch[0] = 24'h800001;
        ch[7] = 24'h7FFFFF;
        set_frame(24'hC00000);
        r0 = rise_cnt;
        drdy_fall(m);
        cycles(1740);
        chk("B ch0", 192'(raw_eeg_array[0 +: 24]), 192'(24'h800001));
        chk("B ch7", 192'(raw_eeg_array[168 +: 24]), 192'(24'h7FFFFF));
        chk("B sclk rises", 192'(rise_cnt - r0), 192'(216));

        // Single overrun mid-SHIFT, then a burst that saturates the counter.
        rand_channels();
        set_frame(24'hC00000 | 24'($urandom_range(0, 24'hFFFFF)));
        dv0 = dv_cnt;
        drdy_fall(m);
        cycles($urandom_range(400, 800));
        drdy_fall(m2);
        cycles(1740);
        chk("ovr single", 192'(overrun_cnt), 192'(1));
        chk("ovr single dv", 192'(dv_cnt - dv0), 192'(1));
        dv0 = dv_cnt;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); adc_drdy_n = 1'b0;
            @(negedge clk);
            @(negedge clk); adc_drdy_n = 1'b1;
            @(negedge clk);
        end
        chk("ovr saturated", 192'(overrun_cnt), 192'(255));
        cycles(800);
        chk("ovr held", 192'(overrun_cnt), 192'(255));
        chk("ovr burst dv", 192'(dv_cnt - dv0), 192'(1));
        exp_last = chan_vec();

        // Abort after bit 100.
        rand_channels();
        set_frame(24'hC00000);
        dv0 = dv_cnt; err0 = err_cnt; r0 = rise_cnt;
        drdy_fall(m);
        for (int k = 0; k < 2000 && (rise_cnt - r0) < 101; k++) @(negedge clk);
        chk("abort reached bit 100", 192'((rise_cnt - r0) >= 101), 192'(1));
        cycles($urandom_range(4, 8));
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort cs_n", 192'(adc_cs_n), 192'(1));
        chk("abort sclk", 192'(adc_sclk), 192'(0));
        cycles(1800);
        chk("abort no dv", 192'(dv_cnt - dv0), 192'(0));
        chk("abort no err", 192'(err_cnt - err0), 192'(0));
        chk("abort raw held", raw_eeg_array, exp_last);
        enable = 1'b1;
        cycles(5);
        rand_channels();
        set_frame(24'hC00000);
        dv0 = dv_cnt;
        drdy_fall(m);
        cycles(1740);
        chk("post-abort dv", 192'(dv_cnt - dv0), 192'(1));
        chk("post-abort raw", raw_eeg_array, chan_vec());
        exp_last = chan_vec();

        // Bad status word.
        rand_channels();
        set_frame(24'h400000);
        dv0 = dv_cnt; err0 = err_cnt;
        drdy_fall(m);
        cycles(1740);
`ifdef BOREAL_ADC_STATUS_CHECK_EN
        chk("bad status err", 192'(err_cnt - err0), 192'(1));
        chk("bad status no dv", 192'(dv_cnt - dv0), 192'(0));
        chk("bad status raw held", raw_eeg_array, exp_last);
`else
        chk("status ignored err", 192'(err_cnt - err0), 192'(0));
        chk("status ignored dv", 192'(dv_cnt - dv0), 192'(1));
        chk("status ignored raw", raw_eeg_array, chan_vec());
`endif

        // Reset mid-SHIFT, then a clean frame.
        rand_channels();
        set_frame(24'hC00000);
        drdy_fall(m);
        cycles(600);
        rst_n = 1'b0;
        #1;
        chk("midrst cs_n", 192'(adc_cs_n), 192'(1));
        chk("midrst sclk", 192'(adc_sclk), 192'(0));
        chk("midrst raw", raw_eeg_array, 192'(0));
        chk("midrst dv", 192'(data_valid), 192'(0));
        chk("midrst err", 192'(frame_err), 192'(0));
        chk("midrst ovr", 192'(overrun_cnt), 192'(0));
        cycles(3);
        rst_n = 1'b1;
        cycles(5);
        rand_channels();
        set_frame(24'hC00000);
        dv0 = dv_cnt;
        drdy_fall(m);
        cycles(1740);
        chk("post-reset dv", 192'(dv_cnt - dv0), 192'(1));
        chk("post-reset raw", raw_eeg_array, chan_vec());

        // Random frames with random stray DRDY falls; the per-cycle model does the checking.
        for (int f = 0; f < 3; f++) begin
            rand_channels();
            set_frame(($urandom_range(0, 3) == 0) ? 24'($urandom) : (24'hC00000 | 24'($urandom_range(0, 24'hFFFFF))));
            drdy_fall(m);
            cycles($urandom_range(50, 1500));
            if ($urandom_range(0, 1) == 1) drdy_fall(m2);
            cycles(1760);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
